// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST transmit arbiter.
//   arb_state_t : arbiter FSM states (IDLE, XFER, GAP)
//   empty_w()   : width of the Avalon-ST empty field for a given data width
package avst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // $clog2(width/8), but never below one bit so an 8-bit bus still has a legal port.
  function automatic int empty_w(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/avst_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req    : request vector, one bit per source
//   ptr    : index of the source holding highest priority this cycle
//   onehot : first requester at or after ptr, wrapping modulo NUM_SRC
//   any    : at least one request is present
module rr_pick #(
  parameter int NUM_SRC = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] onehot,
  output logic               any
);

  logic [PW-1:0] idx;

  // Walk the sources starting at ptr; the first hit wins and blocks later ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_SRC);
      if (onehot == '0 && req[idx]) begin
        onehot[idx] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/avst_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST sink between NUM_SRC sources.
//   clk, rst (async, active-low)
//   en                         : allow new grants (a packet in flight always completes)
//   src_valid/data/sop/eop/empty, src_ready : per-source Avalon-ST sinks, packed by source index
//   out_valid/data/sop/eop/empty, out_ready : shared Avalon-ST source toward the MAC TX FIFO
//   grant                      : one-hot granted source, zero outside XFER
//   pkt_cnt                    : completed packets, wraps
//   err                        : one-cycle pulse on malformed traffic
module avst_tx_arbiter
  import avst_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 2,
  parameter int IPG_CYCLES = 3,
  parameter int CNT_W      = 16,
  localparam int EW        = empty_w(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]      src_sop,
  input  logic [NUM_SRC-1:0]      src_eop,
  input  logic [NUM_SRC*EW-1:0]   src_empty,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [EW-1:0]           out_empty,
  input  logic                    out_ready,
  output logic [NUM_SRC-1:0]      grant,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic                    err
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  arb_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               first_q, first_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] malformed;
  logic [NUM_SRC-1:0] pick_onehot;
  logic               pick_any;
  logic [PW-1:0]      g_idx;
  logic [PW-1:0]      ptr_after;
  logic               accept;

  assign req       = src_valid & src_sop;
  assign malformed = src_valid & ~src_sop;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PW      (PW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  // Output mux: pass the granted source straight through, zero everywhere else.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    g_idx     = '0;
    if (state_q == XFER) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q[i]) begin
          out_valid = src_valid[i];
          out_data  = src_data[i*WIDTH +: WIDTH];
          out_sop   = src_sop[i];
          out_eop   = src_eop[i];
          out_empty = src_empty[i*EW +: EW];
          g_idx     = PW'(i);
        end
      end
    end
  end

  // Ready steering. In IDLE a beat without sop is consumed and discarded; the
  // drop is held off during reset so an aborted source is not drained.
  always_comb begin
    src_ready = '0;
    case (state_q)
      XFER:    src_ready = grant_q & {NUM_SRC{out_ready}};
      IDLE:    if (rst) src_ready = malformed;
      default: src_ready = '0;
    endcase
  end

  assign accept    = out_valid & out_ready;
  assign ptr_after = (g_idx == PW'(NUM_SRC - 1)) ? '0 : g_idx + PW'(1);

  // Next-state logic. first_q marks that the packet's opening beat is still
  // pending, so a later sop inside the same packet can be flagged.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    first_d   = first_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|malformed) err_d = 1'b1;
        if (en && pick_any) begin
          grant_d = pick_onehot;
          first_d = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          first_d = 1'b0;
          if (out_sop && !first_q) err_d = 1'b1;
          if (out_eop) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            rr_ptr_d  = ptr_after;
            grant_d   = '0;
            state_d   = (IPG_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counters; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  assign grant   = grant_q;
  assign pkt_cnt = pkt_cnt_q;
  assign err     = err_q;

endmodule
